// File: rtl/reg_file_pkg.sv
// Shared parameters and types for the write-back register file and its
// outstanding-write scoreboard.
// Optional feature macro: REG_ZERO_EN (GPR0 hard-wired to zero).
package reg_file_pkg;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 3;
    localparam int NUM_REGS     = 2 ** ADDR_W;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = (2 ** CNT_W) - 1;

    typedef logic [CNT_W-1:0]      cnt_t;
    typedef cnt_t [NUM_REGS-1:0]   cnt_vec_t;

    // Net action on one scoreboard counter for the coming edge.
    typedef enum logic [1:0] {
        SB_HOLD,
        SB_INC,
        SB_DEC,
        SB_CLR
    } sb_op_e;

    // Clear wins over everything; a simultaneous inc and dec cancel out.
    function automatic sb_op_e sb_op(input logic clr, input logic inc, input logic dec);
        if (clr)
            return SB_CLR;
        if (inc && !dec)
            return SB_INC;
        if (dec && !inc)
            return SB_DEC;
        return SB_HOLD;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: saturating count of issued-but-not-written-back
// instructions targeting a single GPR. err pulses for an edge whose
// increment would overflow or whose decrement would underflow.
module sb_counter
    import reg_file_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic err
);

    localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);

    sb_op_e op;

    assign op = sb_op(clr, inc, dec);

    // Flag an out-of-range update; the counter itself holds in that case.
    always_comb begin
        err = ((op == SB_INC) && (cnt == CNT_MAX)) ||
              ((op == SB_DEC) && (cnt == '0));
    end

    // Counter state: clear, saturating increment, or floor-limited decrement.
    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (op)
                SB_CLR:  cnt <= '0;
                SB_INC:  if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                SB_DEC:  if (cnt != '0)      cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// GPR file plus private register at the write-back end of the pipeline.
// Two combinational read ports with same-cycle write-through bypass, and a
// per-register outstanding-write scoreboard that raises a decode stall on
// read-after-write hazards.
// Optional feature macro: REG_ZERO_EN -- GPR0 always reads zero, writes to
// it are dropped and it never takes part in the scoreboard.
module reg_file_wb
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic              wb_priv,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_use_a,
    input  logic              rd_use_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] priv_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              flush,
    output logic              stall,
    output logic              sb_err
);

`ifdef REG_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0]   gpr [NUM_REGS];
    logic [DATA_W-1:0]   priv_q;
    cnt_vec_t            cnt;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] err_vec;
    logic                wb_gpr;
    logic                wb_commit;
    logic                iss_go;
    logic                hazard_a;
    logic                hazard_b;
    logic                sb_err_q;

    // A GPR write that actually lands; with GPR0 hard-wired it is dropped.
    assign wb_gpr    = wb_en & ~wb_priv;
    assign wb_commit = wb_gpr & (!ZERO_EN || (wb_addr != '0));

    // An issue only counts when decode is not being held.
    assign iss_go = iss_en & ~stall;

    // GPR array write port.
    // NOTE: the array is reset because every register must read zero after
    // reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                gpr[i] <= '0;
        end else if (wb_commit) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Private register write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            priv_q <= '0;
        else if (wb_en && wb_priv)
            priv_q <= wb_data;
    end

    // Read ports: array value, overridden by the in-flight write-back.
    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        rd_data_a = gpr[rd_addr_a];
        rd_data_b = gpr[rd_addr_b];
        priv_data = priv_q;
        if (wb_commit && (wb_addr == rd_addr_a))
            rd_data_a = wb_data;
        if (wb_commit && (wb_addr == rd_addr_b))
            rd_data_b = wb_data;
        if (ZERO_EN && (rd_addr_a == '0))
            rd_data_a = '0;
        if (ZERO_EN && (rd_addr_b == '0))
            rd_data_b = '0;
        if (wb_en && wb_priv)
            priv_data = wb_data;
    end

    // Scoreboard: one saturating counter per GPR.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc_vec[r] = iss_go && (iss_dst == ADDR_W'(r)) && (!ZERO_EN || (r != 0));
        assign dec_vec[r] = wb_commit && (wb_addr == ADDR_W'(r));

        sb_counter u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .inc (inc_vec[r]),
            .dec (dec_vec[r]),
            .cnt (cnt[r]),
            .err (err_vec[r])
        );
    end

    // RAW hazard per used source; the bypass only resolves the last
    // outstanding write to that register.
    always_comb begin
        hazard_a = rd_use_a && (cnt[rd_addr_a] != '0) &&
                   !((cnt[rd_addr_a] == cnt_t'(1)) && wb_commit && (wb_addr == rd_addr_a)) &&
                   (!ZERO_EN || (rd_addr_a != '0));
        hazard_b = rd_use_b && (cnt[rd_addr_b] != '0) &&
                   !((cnt[rd_addr_b] == cnt_t'(1)) && wb_commit && (wb_addr == rd_addr_b)) &&
                   (!ZERO_EN || (rd_addr_b != '0));
    end

    assign stall = hazard_a | hazard_b;

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err_q <= 1'b0;
        else if (|err_vec)
            sb_err_q <= 1'b1;
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized
// traffic compared against a behavioural model of the register file.
module tb_reg_file_wb;
    import reg_file_pkg::*;

`ifdef REG_ZERO_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en;
    logic              wb_priv;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              rd_use_a;
    logic              rd_use_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] priv_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_dst;
    logic              flush;
    logic              stall;
    logic              sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [DATA_W-1:0] m_gpr [NUM_REGS];
    logic [DATA_W-1:0] m_priv;
    int                m_cnt [NUM_REGS];
    bit                m_err;

    reg_file_wb dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_priv   (wb_priv),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_use_a  (rd_use_a),
        .rd_use_b  (rd_use_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .priv_data (priv_data),
        .iss_en    (iss_en),
        .iss_dst   (iss_dst),
        .flush     (flush),
        .stall     (stall),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    function automatic bit m_wb_lands(input logic [ADDR_W-1:0] a);
        return wb_en && !wb_priv && (wb_addr == a) && !(ZERO && a == 0);
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
        if (ZERO && a == 0) return '0;
        if (m_wb_lands(a))  return wb_data;
        return m_gpr[a];
    endfunction

    function automatic bit m_hazard(input bit u, input logic [ADDR_W-1:0] a);
        if (!u)                               return 1'b0;
        if (ZERO && a == 0)                   return 1'b0;
        if (m_cnt[a] == 0)                    return 1'b0;
        if (m_cnt[a] == 1 && m_wb_lands(a))   return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return m_hazard(rd_use_a, rd_addr_a) || m_hazard(rd_use_b, rd_addr_b);
    endfunction

    function automatic logic [DATA_W-1:0] m_priv_out();
        return (wb_en && wb_priv) ? wb_data : m_priv;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_gpr[i] = '0;
            m_cnt[i] = 0;
        end
        m_priv = '0;
        m_err  = 1'b0;
    endtask

    task automatic m_edge();
        bit st;
        bit inc;
        bit dec;
        st = m_stall();
        for (int r = 0; r < NUM_REGS; r++) begin
            inc = iss_en && !st && (iss_dst == r) && !(ZERO && r == 0);
            dec = m_wb_lands(ADDR_W'(r));
            if (flush)
                m_cnt[r] = 0;
            else if (inc && !dec) begin
                if (m_cnt[r] == MAX_INFLIGHT) m_err = 1'b1;
                else                          m_cnt[r]++;
            end else if (dec && !inc) begin
                if (m_cnt[r] == 0) m_err = 1'b1;
                else               m_cnt[r]--;
            end
        end
        if (wb_en && !wb_priv && !(ZERO && wb_addr == 0))
            m_gpr[wb_addr] = wb_data;
        if (wb_en && wb_priv)
            m_priv = wb_data;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else     m_edge();
        #1;
    endtask

    task automatic idle();
        wb_en = 0; wb_priv = 0; wb_addr = '0; wb_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rd_use_a = 0; rd_use_b = 0;
        iss_en = 0; iss_dst = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] d);
        idle();
        iss_en = 1; iss_dst = d;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        wb_en = 1; wb_addr = 3'd1; wb_data = 16'h1111; tick();
        idle(); wb_en = 1; wb_priv = 1; wb_data = 16'h2222; tick();
        issue(3'd3);
        idle(); wb_en = 1; wb_addr = 3'd6; wb_data = 16'h6666; tick();
        idle(); rd_use_a = 1; rd_addr_a = 3'd3; rd_addr_b = 3'd6;
        #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b expected 1", stall); end
        n_checks++; if (rd_data_b !== 16'h6666) begin n_fail++; $display("FAIL pre_reset_rd_b: got %h expected 6666", rd_data_b); end
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sb_err: got %b expected 1", sb_err); end
        rst = 1'b1;
        #1;
        n_checks++; if (rd_data_a !== 16'h0) begin n_fail++; $display("FAIL reset_rd_a: got %h expected 0000", rd_data_a); end
        n_checks++; if (rd_data_b !== 16'h0) begin n_fail++; $display("FAIL reset_rd_b: got %h expected 0000", rd_data_b); end
        n_checks++; if (priv_data !== 16'h0) begin n_fail++; $display("FAIL reset_priv: got %h expected 0000", priv_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err: got %b expected 0", sb_err); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        idle(); wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF; rd_addr_a = 3'd3;
        #2;
        n_checks++; if (rd_data_a !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected beef", rd_data_a); end
        tick();
        idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #2;
        n_checks++; if (rd_data_a !== 16'hBEEF) begin n_fail++; $display("FAIL array_rd_a: got %h expected beef", rd_data_a); end
        n_checks++; if (rd_data_b !== 16'hBEEF) begin n_fail++; $display("FAIL array_rd_b: got %h expected beef", rd_data_b); end
        tick();
    endtask

    task automatic test_priv();
        issue(3'd3);
        idle(); wb_en = 1; wb_priv = 1; wb_addr = 3'd3; wb_data = 16'h1234; rd_addr_a = 3'd3;
        #2;
        n_checks++; if (priv_data !== 16'h1234) begin n_fail++; $display("FAIL priv_bypass: got %h expected 1234", priv_data); end
        n_checks++; if (rd_data_a !== 16'hBEEF) begin n_fail++; $display("FAIL priv_no_gpr_bypass: got %h expected beef", rd_data_a); end
        tick();
        idle(); rd_use_a = 1; rd_addr_a = 3'd3;
        #2;
        n_checks++; if (priv_data !== 16'h1234) begin n_fail++; $display("FAIL priv_stored: got %h expected 1234", priv_data); end
        n_checks++; if (rd_data_a !== 16'hBEEF) begin n_fail++; $display("FAIL priv_gpr3_kept: got %h expected beef", rd_data_a); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL priv_cnt3_kept: got %b expected 1", stall); end
        wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL priv_last_wb_release: got %b expected 0", stall); end
        tick();
    endtask

    task automatic test_raw_stall();
        do_reset();
        issue(3'd5);
        idle(); rd_use_a = 1; rd_addr_a = 3'd5;
        #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", stall); end
        wb_en = 1; wb_addr = 3'd5; wb_data = 16'h5555;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_resolved: got %b expected 0", stall); end
        n_checks++; if (rd_data_a !== 16'h5555) begin n_fail++; $display("FAIL raw_bypass_data: got %h expected 5555", rd_data_a); end
        tick();
        issue(3'd5);
        issue(3'd5);
        idle(); rd_use_a = 1; rd_addr_a = 3'd5; wb_en = 1; wb_addr = 3'd5; wb_data = 16'h6666;
        #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_two_outstanding: got %b expected 1", stall); end
        tick();
        idle(); rd_use_b = 1; rd_addr_b = 3'd5; iss_en = 1; iss_dst = 3'd5;
        #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_port_b: got %b expected 1", stall); end
        tick();
        idle(); rd_use_b = 1; rd_addr_b = 3'd5; wb_en = 1; wb_addr = 3'd5; wb_data = 16'h7777;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_stalled_issue_ignored: got %b expected 0", stall); end
        n_checks++; if (rd_data_b !== 16'h7777) begin n_fail++; $display("FAIL raw_bypass_b: got %h expected 7777", rd_data_b); end
        tick();
        idle(); rd_use_a = 1; rd_addr_a = 3'd5;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_drained: got %b expected 0", stall); end
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL raw_no_err: got %b expected 0", sb_err); end
        tick();
    endtask

    task automatic test_overflow();
        bit exp_st;
        do_reset();
        for (int i = 0; i < 3; i++) issue(3'd2);
        idle();
        #2;
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL ovf_three_ok: got %b expected 0", sb_err); end
        issue(3'd2);
        idle(); rd_use_a = 1; rd_addr_a = 3'd2;
        #2;
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", sb_err); end
        for (int k = 0; k < 3; k++) begin
            wb_en = 1; wb_addr = 3'd2; wb_data = DATA_W'(k);
            exp_st = (k < 2);
            #2;
            n_checks++; if (stall !== exp_st) begin n_fail++; $display("FAIL ovf_saturated_wb%0d: got %b expected %b", k, stall, exp_st); end
            tick();
        end
        idle(); rd_use_a = 1; rd_addr_a = 3'd2;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", stall); end
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b expected 1", sb_err); end
        tick();
    endtask

    task automatic test_underflow();
        do_reset();
        #2;
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL udf_clean: got %b expected 0", sb_err); end
        wb_en = 1; wb_addr = 3'd6; wb_data = 16'h0A0A;
        tick();
        idle(); rd_addr_a = 3'd6;
        #2;
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL udf_err: got %b expected 1", sb_err); end
        n_checks++; if (rd_data_a !== 16'h0A0A) begin n_fail++; $display("FAIL udf_data: got %h expected 0a0a", rd_data_a); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issue(3'd4);
        issue(3'd4);
        idle(); rd_use_a = 1; rd_addr_a = 3'd4; flush = 1; wb_en = 1; wb_addr = 3'd4; wb_data = 16'h00AA;
        #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b expected 1", stall); end
        tick();
        idle(); rd_use_a = 1; rd_addr_a = 3'd4;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_cleared: got %b expected 0", stall); end
        n_checks++; if (rd_data_a !== 16'h00AA) begin n_fail++; $display("FAIL flush_data: got %h expected 00aa", rd_data_a); end
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b expected 0", sb_err); end
        tick();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e_a;
        logic [DATA_W-1:0] e_b;
        logic [DATA_W-1:0] e_p;
        bit                e_st;
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_priv   = ($urandom_range(0, 4) == 0);
            wb_addr   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            wb_data   = DATA_W'($urandom);
            rd_addr_a = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            rd_addr_b = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            rd_use_a  = $urandom_range(0, 1);
            rd_use_b  = $urandom_range(0, 1);
            iss_en    = $urandom_range(0, 1);
            iss_dst   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            flush     = ($urandom_range(0, 19) == 0);
            #2;
            e_a  = m_read(rd_addr_a);
            e_b  = m_read(rd_addr_b);
            e_p  = m_priv_out();
            e_st = m_stall();
            n_checks++; if (rd_data_a !== e_a) begin n_fail++; $display("FAIL rand_rd_a[%0d]: got %h expected %h", n, rd_data_a, e_a); end
            n_checks++; if (rd_data_b !== e_b) begin n_fail++; $display("FAIL rand_rd_b[%0d]: got %h expected %h", n, rd_data_b, e_b); end
            n_checks++; if (priv_data !== e_p) begin n_fail++; $display("FAIL rand_priv[%0d]: got %h expected %h", n, priv_data, e_p); end
            n_checks++; if (stall !== e_st) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, e_st); end
            n_checks++; if (sb_err !== m_err) begin n_fail++; $display("FAIL rand_sb_err[%0d]: got %b expected %b", n, sb_err, m_err); end
            tick();
        end
    endtask

    initial begin
        m_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_priv();
        test_raw_stall();
        test_overflow();
        test_underflow();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file at the consumer end of the write-back interface.
- Write-back drives a result, destination address, write enable and a private/GPR select; this block commits the result and serves two combinational read ports to decode.
- A per-register outstanding-write scoreboard drives a decode stall.
- Sits between the decode stage (reads, issue) and the write-back stage (writes).

Parameters:
DATA_W, 16, register width
ADDR_W, 3, GPR address width
NUM_REGS, 8, number of GPRs (2**ADDR_W)
CNT_W, 2, width of each outstanding-write counter; max in-flight = 2**CNT_W-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wb_en  in  1  write-back commit strobe (regWrite)
wb_priv  in  1  1 = write private register, 0 = write GPR wb_addr
wb_addr  in  ADDR_W  write-back GPR destination
wb_data  in  DATA_W  write-back result (already muxed mem/alu)
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_use_a  in  1  decode instruction uses source A
rd_use_b  in  1  decode instruction uses source B
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
priv_data  out  DATA_W  private register contents
iss_en  in  1  decode issues an instruction that will write a GPR
iss_dst  in  ADDR_W  issued instruction's GPR destination
flush  in  1  pipeline flush; clears scoreboard
stall  out  1  decode must hold (RAW hazard)
sb_err  out  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - all GPRs, the private register and all counters go to 0; sb_err goes to 0.
  - Outputs follow combinationally: rd_data_* = 0, priv_data = 0, stall = 0.
- Write: on a rising edge with wb_en=1:
  - wb_priv=0: GPR[wb_addr] <= wb_data.
  - wb_priv=1: private register <= wb_data; no GPR or counter change.
- Read: combinational with write-through bypass.
  - If wb_en & !wb_priv & wb_addr==rd_addr_x, rd_data_x = wb_data; otherwise rd_data_x = GPR[rd_addr_x].
  - priv_data also bypasses when wb_en & wb_priv.
- Scoreboard: one CNT_W-bit counter per GPR, updated each edge.
  - inc when iss_en & iss_dst==r & !stall.
  - dec when wb_en & !wb_priv & wb_addr==r.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc at max (3): counter holds; sb_err <= 1.
  - dec at 0: counter holds; sb_err <= 1.
  - sb_err clears only on reset.
- Stall (combinational), per used source x:
  - hazard_x = rd_use_x & cnt[rd_addr_x]!=0 & !(cnt[rd_addr_x]==1 & wb_en & !wb_priv & wb_addr==rd_addr_x).
  - Bypass resolves a hazard only when the current write-back is the last one outstanding.
  - stall = hazard_a | hazard_b. While stalled, iss_en is ignored.
- Flush: on an edge with flush=1, all counters <= 0, overriding inc/dec that cycle.
  - A simultaneous wb_en write still commits data.
  - The pipeline guarantees flushed instructions never assert wb_en.
- No output latency: all outputs are combinational from state plus current inputs.
- Write data is visible in the array one edge after wb_en, and through the bypass in the same cycle.

Optional Feature:
- Macro: REG_ZERO_EN.
- Defined:
  - GPR0 reads 0 always, with no bypass.
  - Writes to GPR0 are dropped.
  - Counter 0 never increments.
  - Sources at address 0 never stall.
- Undefined: GPR0 is an ordinary register.

Decomposition:
- Package reg_file_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS, CNT_W
  - MAX_INFLIGHT constant
  - a typedef for the counter vector
- One sub-module, sb_counter: a single saturating inc/dec/clear counter with an error pulse output, instantiated NUM_REGS times.

Test Plan:
- rst=1 mid-stream after writes -> all rd_data=0, priv_data=0, stall=0, sb_err=0 immediately, without a clock edge.
- Same-cycle bypass: wb_en=1, wb_priv=0, wb_addr=3, wb_data=16'hBEEF, rd_addr_a=3 -> rd_data_a=BEEF that cycle; GPR3=BEEF on the next cycle.
- Private write: wb_priv=1, wb_addr=3, wb_data=16'h1234 -> priv_data=1234, GPR3 unchanged, counter 3 unchanged.
- RAW stall:
  - iss_en dst=5 (cnt5=1); next cycle rd_use_a=1, rd_addr_a=5 -> stall=1.
  - Cycle wb_en addr=5 -> stall=0 with data bypassed.
  - Two issues to R5 (cnt=2) plus one write-back -> stall stays 1.
- Overflow/underflow: four issues to R2 with no write-back -> cnt holds 3, sb_err=1 and stays 1. Separately after reset, wb to R6 with cnt6=0 -> sb_err=1.
- Flush: cnt4=2; flush together with wb_en addr=4 data=16'h00AA -> cnt4=0, GPR4=00AA, stall=0 for source R4.
